// File: rtl/video_scanlines.sv
// CRT-style scanline darkening on the mixer's pixel stream: odd lines are attenuated
// by a strength latched at frame start; one pixel of latency, same interface shape.
module video_scanlines #(
  parameter bit PARITY_RESET = 1'b0,
  parameter bit DE_LINES     = 1'b0
) (
  input  logic       CLK_VIDEO,
  input  logic       RESET,
  input  logic       ce_pix,
  input  logic [1:0] scanlines,
  input  logic [7:0] R_in,
  input  logic [7:0] G_in,
  input  logic [7:0] B_in,
  input  logic       HS_in,
  input  logic       VS_in,
  input  logic       DE_in,
  output logic       CE_OUT,
  output logic [7:0] R_out,
  output logic [7:0] G_out,
  output logic [7:0] B_out,
  output logic       HS_out,
  output logic       VS_out,
  output logic       DE_out
);

  localparam int DATA_W = 8;

  function automatic logic [DATA_W-1:0] darken(input logic [DATA_W-1:0] x,
                                               input logic [1:0]        mode);
    case (mode)
      2'd1:    darken = x - (x >> 2);
      2'd2:    darken = x >> 1;
      2'd3:    darken = x >> 2;
      default: darken = x;
    endcase
  endfunction

  logic              ce_out_q, ce_out_d;
  logic [DATA_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic              parity_q, parity_d;
  logic [1:0]        mode_lat_q, mode_lat_d;
  logic              old_hs_q, old_hs_d, old_vs_q, old_vs_d;
  logic              line_had_de_q, line_had_de_d;
  logic              vs_rise, hs_rise, dk;

  always_comb begin
    ce_out_d      = ce_pix;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    de_d          = de_q;
    parity_d      = parity_q;
    mode_lat_d    = mode_lat_q;
    old_hs_d      = old_hs_q;
    old_vs_d      = old_vs_q;
    line_had_de_d = line_had_de_q;
    vs_rise       = VS_in & ~old_vs_q;
    hs_rise       = HS_in & ~old_hs_q;
    // Darkening uses the parity held before this pixel, so the HS edge pixel is unaffected.
    dk            = parity_q & (mode_lat_q != 2'd0) & DE_in;

    if (ce_pix) begin
      r_d      = dk ? darken(R_in, mode_lat_q) : R_in;
      g_d      = dk ? darken(G_in, mode_lat_q) : G_in;
      b_d      = dk ? darken(B_in, mode_lat_q) : B_in;
      hs_d     = HS_in;
      vs_d     = VS_in;
      de_d     = DE_in;
      old_hs_d = HS_in;
      old_vs_d = VS_in;

      if (vs_rise) begin
        parity_d      = PARITY_RESET;
        mode_lat_d    = scanlines;
        line_had_de_d = 1'b0;
      end else if (hs_rise) begin
        if (!DE_LINES || line_had_de_q)
          parity_d = ~parity_q;
        line_had_de_d = 1'b0;
      end else if (DE_in) begin
        line_had_de_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (RESET) begin
      ce_out_q      <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      parity_q      <= PARITY_RESET;
      mode_lat_q    <= 2'd0;
      old_hs_q      <= 1'b0;
      old_vs_q      <= 1'b0;
      line_had_de_q <= 1'b0;
    end else begin
      ce_out_q      <= ce_out_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      parity_q      <= parity_d;
      mode_lat_q    <= mode_lat_d;
      old_hs_q      <= old_hs_d;
      old_vs_q      <= old_vs_d;
      line_had_de_q <= line_had_de_d;
    end
  end

  assign CE_OUT = ce_out_q;
  assign R_out  = r_q;
  assign G_out  = g_q;
  assign B_out  = b_q;
  assign HS_out = hs_q;
  assign VS_out = vs_q;
  assign DE_out = de_q;

endmodule
